// File: rtl/data_mem_ctrl_if.sv
// Word-wide ack-based data bus between the data-memory controller and memory.
// master drives the request side; slave returns ack and read data.
interface data_mem_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller behind the MEM stage: runs one aligned access
// on the ack-based bus, stalls the pipeline meanwhile, returns zero-extended loads.
module data_mem_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            address,
  input  logic [31:0]            data_write,
  input  logic [1:0]             size,
  input  logic                   mem_read,
  input  logic                   mem_write,
  output logic [31:0]            data_mem,
  output logic                   stall,
  output logic                   misalign,
  output logic                   bus_err,
  data_mem_ctrl_if.master        bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lo_q, size_q;
  logic             req, is_byte, is_half, misaligned, start, timeout_hit;
  logic [3:0]       be;
  logic [31:0]      wdata, rd_sh, rdata_al;

  assign req         = mem_read | mem_write;
  assign is_half     = (size == 2'b01);
  assign is_byte     = (size == 2'b10);
  assign misaligned  = (is_half & address[0]) | (~is_half & ~is_byte & (|address[1:0]));
  assign start       = (state == IDLE) & req & ~misaligned;
  assign misalign    = req & misaligned & (state == IDLE);
  assign stall       = start | (state == REQ);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  // Lane positioning: replicate narrow store data so every enabled lane sees it.
  always_comb begin
    be    = 4'b1111;
    wdata = data_write;
    if (is_byte) begin
      be    = 4'b0001 << address[1:0];
      wdata = {4{data_write[7:0]}};
    end else if (is_half) begin
      be    = 4'b0011 << {address[1], 1'b0};
      wdata = {2{data_write[15:0]}};
    end
  end

  // Halves are aligned, so lo_q is 0 or 2 and one byte-granular shift serves both sizes.
  always_comb begin
    rd_sh    = bus.bus_rdata >> {lo_q, 3'b000};
    rdata_al = bus.bus_rdata;
    if (size_q == 2'b10)      rdata_al = {24'b0, rd_sh[7:0]};
    else if (size_q == 2'b01) rdata_al = {16'b0, rd_sh[15:0]};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (bus.bus_ack || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      data_mem      <= '0;
      bus_err       <= 1'b0;
      cnt           <= '0;
      lo_q          <= '0;
      size_q        <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (start) begin
          bus.bus_req   <= 1'b1;
          bus.bus_we    <= mem_write;
          bus.bus_addr  <= address[31:2];
          bus.bus_be    <= be;
          bus.bus_wdata <= wdata;
          lo_q          <= address[1:0];
          size_q        <= size;
          cnt           <= '0;
        end
        REQ: begin
          if (bus.bus_ack) begin
            bus.bus_req <= 1'b0;
            if (!bus.bus_we) data_mem <= rdata_al;
          end else if (timeout_hit) begin
            bus.bus_req <= 1'b0;
            bus_err     <= 1'b1;
            data_mem    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: reads, writes, misalignment, timeout and reset abort.
module tb_data_mem_ctrl;
  logic        clk, rst;
  logic [31:0] address, data_write;
  logic [1:0]  size;
  logic        mem_read, mem_write, rd0;
  logic [31:0] data_mem, data_mem0;
  logic        stall, misalign, bus_err, stall0, misalign0, bus_err0;
  int          checks = 0, failures = 0;
  int          n, reqc;
  logic        seen, got;

  data_mem_ctrl_if bif();
  data_mem_ctrl_if bif0();

  data_mem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .address(address), .data_write(data_write), .size(size),
    .mem_read(mem_read), .mem_write(mem_write), .data_mem(data_mem), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .bus(bif.master)
  );

  // Second instance with the timeout disabled; bus_ack stays low for it.
  data_mem_ctrl #(.TIMEOUT(0), .CNT_W(5)) dut0 (
    .clk(clk), .rst(rst), .address(address), .data_write(data_write), .size(size),
    .mem_read(rd0), .mem_write(1'b0), .data_mem(data_mem0), .stall(stall0),
    .misalign(misalign0), .bus_err(bus_err0), .bus(bif0.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; address = '0; data_write = '0; size = '0;
    mem_read = 1'b0; mem_write = 1'b0; rd0 = 1'b0;
    bif.bus_ack = 1'b0; bif.bus_rdata = '0;
    bif0.bus_ack = 1'b0; bif0.bus_rdata = '0;
    step(); step(); smp();
    chk("rst_req",   bif.bus_req, 0);
    chk("rst_we",    bif.bus_we, 0);
    chk("rst_be",    bif.bus_be, 0);
    chk("rst_addr",  bif.bus_addr, 0);
    chk("rst_wdata", bif.bus_wdata, 0);
    chk("rst_dmem",  data_mem, 0);
    chk("rst_err",   bus_err, 0);

    // aligned word read, ack in first REQ cycle
    step(); rst = 1'b0; address = 32'h100; size = 2'b00; mem_read = 1'b1;
    smp();
    chk("wr_c0_stall", stall, 1);
    chk("wr_c0_req",   bif.bus_req, 0);
    step(); bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEADBEEF;
    smp();
    chk("wr_c1_stall", stall, 1);
    chk("wr_c1_req",   bif.bus_req, 1);
    chk("wr_addr",     bif.bus_addr, 32'h40);
    chk("wr_be",       bif.bus_be, 4'b1111);
    chk("wr_we",       bif.bus_we, 0);
    step(); bif.bus_ack = 1'b0;
    smp();
    chk("wr_dmem",     data_mem, 32'hDEADBEEF);
    chk("wr_done_stall", stall, 0);
    chk("wr_done_req", bif.bus_req, 0);
    step(); mem_read = 1'b0;

    // byte read at lane 3, three wait cycles
    step(); address = 32'h103; size = 2'b10; mem_read = 1'b1; n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      bif.bus_ack = (i == 4); bif.bus_rdata = 32'h80112233;
      smp();
      if (stall) n++;
      if (i == 1) chk("br_be", bif.bus_be, 4'b1000);
    end
    chk("br_dmem",  data_mem, 32'h00000080);
    chk("br_stall_cycles", n, 5);
    chk("br_done_stall", stall, 0);
    step(); mem_read = 1'b0; bif.bus_ack = 1'b0;

    // half write, then byte write
    step(); address = 32'h202; size = 2'b01; data_write = 32'h1234ABCD; mem_write = 1'b1;
    smp();
    chk("hw_c0_stall", stall, 1);
    step(); bif.bus_ack = 1'b1;
    smp();
    chk("hw_we",    bif.bus_we, 1);
    chk("hw_be",    bif.bus_be, 4'b1100);
    chk("hw_wdata", bif.bus_wdata, 32'hABCDABCD);
    step(); bif.bus_ack = 1'b0;
    smp();
    chk("hw_dmem_hold", data_mem, 32'h00000080);
    chk("hw_done_stall", stall, 0);
    step(); address = 32'h101; size = 2'b10; data_write = 32'h0000005A;
    smp();
    step(); bif.bus_ack = 1'b1;
    smp();
    chk("bw_be",    bif.bus_be, 4'b0010);
    chk("bw_wdata", bif.bus_wdata, 32'h5A5A5A5A);
    step(); bif.bus_ack = 1'b0;
    smp();
    step(); mem_write = 1'b0;

    // misaligned word read, then misaligned half write
    step(); address = 32'h101; size = 2'b00; mem_read = 1'b1;
    smp();
    chk("mw_misalign", misalign, 1);
    chk("mw_stall",    stall, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); smp(); seen |= bif.bus_req; end
    chk("mw_no_req", seen, 0);
    step(); address = 32'h203; size = 2'b01; mem_read = 1'b0; mem_write = 1'b1;
    smp();
    chk("mh_misalign", misalign, 1);
    chk("mh_stall",    stall, 0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); smp(); seen |= bif.bus_req; end
    chk("mh_no_req",   seen, 0);
    chk("mh_dmem_hold", data_mem, 32'h00000080);
    step(); mem_write = 1'b0;
    smp();
    chk("m_clear", misalign, 0);

    // timeout with bus_ack held low
    step(); address = 32'h300; size = 2'b00; mem_read = 1'b1; reqc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      smp();
      if (bif.bus_req) reqc++;
      if (bus_err) got = 1'b1;
      if (!got) step();
    end
    chk("to_err_seen",   got, 1);
    chk("to_req_cycles", reqc, 16);
    chk("to_dmem",       data_mem, 0);
    chk("to_stall",      stall, 0);
    chk("to_req_low",    bif.bus_req, 0);
    step(); mem_read = 1'b0;
    smp();
    chk("to_err_pulse", bus_err, 0);
    chk("to_idle_stall", stall, 0);
    step(); smp();
    chk("to_idle_req", bif.bus_req, 0);

    // timeout disabled: request never gives up
    step(); rd0 = 1'b1; reqc = 0; seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (bif0.bus_req) reqc++;
      seen |= bus_err0;
      step();
    end
    chk("nt_req_cycles", reqc, 39);
    chk("nt_no_err",     seen, 0);
    chk("nt_stall",      stall0, 1);

    // read+write together is a write; reset on 2nd REQ cycle aborts it
    address = 32'h400; size = 2'b00; mem_read = 1'b1; mem_write = 1'b1; rd0 = 1'b0;
    smp();
    step(); smp();
    chk("rw_we",  bif.bus_we, 1);
    chk("rw_req", bif.bus_req, 1);
    step(); rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    smp();
    step(); rst = 1'b0; bif.bus_ack = 1'b1; bif.bus_rdata = 32'hCAFEF00D;
    smp();
    chk("ra_req",   bif.bus_req, 0);
    chk("ra_stall", stall, 0);
    chk("ra_we",    bif.bus_we, 0);
    chk("ra_be",    bif.bus_be, 0);
    chk("ra_addr",  bif.bus_addr, 0);
    chk("ra_wdata", bif.bus_wdata, 0);
    chk("ra_err",   bus_err, 0);
    chk("ra_req0",  bif0.bus_req, 0);
    step(); bif.bus_ack = 1'b0;
    smp();
    chk("ra_ack_ignored_dmem", data_mem, 0);
    chk("ra_ack_ignored_req",  bif.bus_req, 0);
    chk("ra_ack_ignored_stall", stall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
